// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_e;

    // Counter must hold the value MAX_BURST itself.
    function automatic int beat_cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted valid at or after the pointer, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    int w_j;

    // Scan from the farthest offset down so the nearest hit is written last and wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        w_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = (int'(ptr_i) + k) % NUM_REQ;
            if (valid_i[w_j]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; throttles on almost-full
// and sequences single-cycle FIFO flushes.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_alm_full_i,
    output logic                          fifo_push_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    input  logic                          flush_req_i,
    output logic                          fifo_flush_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          busy_o
);

    localparam int               CNT_W     = beat_cnt_width(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] w_grant_idx_nxt;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_ptr_inc;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;
    logic             w_found;
    logic             w_sel_valid;
    logic             w_sel_ready;
    logic             w_push;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (r_rr_ptr),
        .found_o (w_found),
        .idx_o   (w_win_idx)
    );

    assign w_sel_valid = req_valid_i[r_grant_idx];
    assign w_ptr_inc   = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + 1'b1;
    assign fifo_data_o = req_data_i[int'(r_grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign grant_idx_o = r_grant_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_idx_nxt = r_grant_idx;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_sel_ready     = 1'b0;
        w_push          = 1'b0;
        req_ready_o     = '0;
        fifo_push_o     = 1'b0;
        fifo_flush_o    = 1'b0;
        busy_o          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (flush_req_i) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_found && !fifo_alm_full_i) begin
                    w_state_nxt     = ST_BURST;
                    w_grant_idx_nxt = w_win_idx;
                    w_beat_cnt_nxt  = '0;
                end
            end

            ST_BURST: begin
                busy_o                   = 1'b1;
                w_sel_ready              = !fifo_full_i && !flush_req_i;
                w_push                   = w_sel_valid && w_sel_ready;
                req_ready_o[r_grant_idx] = w_sel_ready;
                fifo_push_o              = w_push;
                // Full stalls hold the burst without counting a beat.
                if (flush_req_i) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_push && (r_beat_cnt == LAST_BEAT)) begin
                    w_state_nxt    = ST_IDLE;
                    w_rr_ptr_nxt   = w_ptr_inc;
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end else if (!w_sel_valid) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = w_ptr_inc;
                end else if (w_push) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end

            ST_FLUSH: begin
                busy_o       = 1'b1;
                fifo_flush_o = 1'b1;
                w_state_nxt  = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=32).
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic         fifo_alm_full;
    logic         fifo_push;
    logic [31:0]  fifo_data;
    logic         flush_req;
    logic         fifo_flush;
    logic [1:0]   grant_idx;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    fifo_push_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .MAX_BURST  (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .fifo_full_i     (fifo_full),
        .fifo_alm_full_i (fifo_alm_full),
        .fifo_push_o     (fifo_push),
        .fifo_data_o     (fifo_data),
        .flush_req_i     (flush_req),
        .fifo_flush_o    (fifo_flush),
        .grant_idx_o     (grant_idx),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic [3:0] v, input logic full, input logic alm,
                         input logic flush, input logic r);
        @(negedge clk);
        req_valid     = v;
        fifo_full     = full;
        fifo_alm_full = alm;
        flush_req     = flush;
        rst           = r;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] rdy, input logic psh,
                              input logic bsy, input logic fls, input int gidx);
        chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".push"},  32'(fifo_push), 32'(psh));
        chk({tag, ".busy"},  32'(busy),      32'(bsy));
        chk({tag, ".flush"}, 32'(fifo_flush), 32'(fls));
        if (bsy) chk({tag, ".gidx"}, 32'(grant_idx), 32'(gidx));
        if (psh) chk({tag, ".data"}, fifo_data, 32'hC0DE_0000 + 32'(gidx));
    endtask

    initial begin
        logic [0:14] a_push;
        logic [0:14] a_busy;
        logic [3:0]  oh;
        int          g;
        int          ph;

        a_push = 15'b011110111101100;
        a_busy = 15'b011110111101110;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        req_valid = '0; fifo_full = 0; fifo_alm_full = 0; flush_req = 0; rst = 1;

        // Reset state
        drive(4'b0000, 0, 0, 0, 1);
        drive(4'b0000, 0, 0, 0, 1);
        drive(4'b0000, 0, 0, 0, 0);
        expect_out("rst", 4'b0000, 0, 0, 0, 0);
        chk("rst.ptr",  32'(dut.r_rr_ptr), 0);
        chk("rst.gidx", 32'(grant_idx), 0);

        // Burst length: requester 2 alone, 10 beats -> 4,4,2
        for (int k = 0; k < 15; k++) begin
            drive((k <= 12) ? 4'b0100 : 4'b0000, 0, 0, 0, 0);
            expect_out($sformatf("burst%0d", k), a_busy[k] ? 4'b0100 : 4'b0000,
                       a_push[k], a_busy[k], 0, 2);
            if (k == 5 || k == 10 || k == 14)
                chk($sformatf("burst%0d.ptr", k), 32'(dut.r_rr_ptr), 3);
        end

        // Rotation: all requesters valid, order 0,1,2,3,0
        drive(4'b0000, 0, 0, 0, 1);
        for (int k = 0; k < 25; k++) begin
            drive(4'b1111, 0, 0, 0, 0);
            ph = k % 5;
            g  = (k / 5) % 4;
            oh = 4'b0001 << g;
            if (ph == 0) expect_out($sformatf("rot%0d", k), 4'b0000, 0, 0, 0, 0);
            else         expect_out($sformatf("rot%0d", k), oh, 1, 1, 0, g);
        end

        // Flush mid-burst of requester 1, requester 1 wins again afterwards
        drive(4'b1111, 0, 0, 0, 0);
        expect_out("fl0", 4'b0000, 0, 0, 0, 0);
        chk("fl0.ptr", 32'(dut.r_rr_ptr), 1);
        drive(4'b1111, 0, 0, 0, 0);
        expect_out("fl1", 4'b0010, 1, 1, 0, 1);
        drive(4'b1111, 0, 0, 1, 0);
        expect_out("fl2", 4'b0000, 0, 1, 0, 1);
        drive(4'b1111, 0, 0, 0, 0);
        expect_out("fl3", 4'b0000, 0, 1, 1, 1);
        drive(4'b1111, 0, 0, 0, 0);
        expect_out("fl4", 4'b0000, 0, 0, 0, 1);
        chk("fl4.ptr", 32'(dut.r_rr_ptr), 1);
        for (int k = 5; k < 9; k++) begin
            drive(4'b1111, 0, 0, 0, 0);
            expect_out($sformatf("fl%0d", k), 4'b0010, 1, 1, 0, 1);
        end
        drive(4'b0000, 0, 0, 0, 0);
        expect_out("fl9", 4'b0000, 0, 0, 0, 0);
        chk("fl9.ptr", 32'(dut.r_rr_ptr), 2);

        // Full stall after beat 2 of requester 2
        drive(4'b0100, 0, 0, 0, 0);
        expect_out("st0", 4'b0000, 0, 0, 0, 0);
        for (int k = 1; k < 8; k++) begin
            if (k >= 3 && k <= 5) begin
                drive(4'b0100, 1, 0, 0, 0);
                expect_out($sformatf("st%0d", k), 4'b0000, 0, 1, 0, 2);
            end else begin
                drive(4'b0100, 0, 0, 0, 0);
                expect_out($sformatf("st%0d", k), 4'b0100, 1, 1, 0, 2);
            end
        end
        drive(4'b0000, 0, 0, 0, 0);
        expect_out("st8", 4'b0000, 0, 0, 0, 0);
        chk("st8.ptr", 32'(dut.r_rr_ptr), 3);

        // Almost-full throttle in IDLE, ignored mid-burst
        for (int k = 0; k < 3; k++) begin
            drive(4'b1111, 0, 1, 0, 0);
            expect_out($sformatf("af%0d", k), 4'b0000, 0, 0, 0, 0);
        end
        drive(4'b1111, 0, 0, 0, 0);
        expect_out("af3", 4'b0000, 0, 0, 0, 0);
        drive(4'b1111, 0, 0, 0, 0);
        expect_out("af4", 4'b1000, 1, 1, 0, 3);
        for (int k = 5; k < 8; k++) begin
            drive(4'b1111, 0, 1, 0, 0);
            expect_out($sformatf("af%0d", k), 4'b1000, 1, 1, 0, 3);
        end
        drive(4'b1111, 0, 1, 0, 0);
        expect_out("af8", 4'b0000, 0, 0, 0, 0);
        chk("af8.ptr", 32'(dut.r_rr_ptr), 0);
        drive(4'b1111, 0, 1, 0, 0);
        expect_out("af9", 4'b0000, 0, 0, 0, 0);
        drive(4'b0000, 0, 0, 0, 0);

        // Reset during beat 3 of a burst whose pointer has moved to 2
        for (int k = 0; k < 10; k++) begin
            drive(4'b0110, 0, 0, 0, (k == 8));
            if (k == 0 || k == 5)   expect_out($sformatf("rm%0d", k), 4'b0000, 0, 0, 0, 0);
            else if (k <= 4)        expect_out($sformatf("rm%0d", k), 4'b0010, 1, 1, 0, 1);
            else if (k <= 8)        expect_out($sformatf("rm%0d", k), 4'b0100, 1, 1, 0, 2);
            else                    expect_out($sformatf("rm%0d", k), 4'b0000, 0, 0, 0, 0);
            if (k == 5) chk("rm5.ptr", 32'(dut.r_rr_ptr), 2);
        end
        chk("rm9.ptr",   32'(dut.r_rr_ptr), 0);
        chk("rm9.gidx",  32'(grant_idx), 0);
        chk("rm9.state", 32'(dut.r_state), 32'(ST_IDLE));
        drive(4'b0110, 0, 0, 0, 0);
        expect_out("rm10", 4'b0010, 1, 1, 0, 1);
        drive(4'b0000, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
